// File: rtl/uart_bist_pkg.sv
// Shared types and constants for the UART loopback BIST.
// Pattern selection, LFSR seed/taps and the controller state encoding.
package uart_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PATTERN_INC  = 0;
  localparam int PATTERN_LFSR = 1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci LFSR
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Deterministic beat generator: incrementing counter or LFSR16.
// Output is the low DATA_BITS of the state; advances only on request.
module bist_pattern_gen
  import uart_bist_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PATTERN_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reseed,
  input  logic                 advance,
  output logic [DATA_BITS-1:0] data
);

  localparam logic [15:0] SEED =
    (PATTERN_MODE == PATTERN_LFSR) ? LFSR_SEED : 16'h0000;

  logic [15:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (reseed) begin
      q <= SEED;
    end else if (advance) begin
      if (PATTERN_MODE == PATTERN_LFSR) q <= lfsr_next(q);
      else                              q <= q + 16'd1;
    end
  end

  assign data = q[DATA_BITS-1:0];

endmodule

// File: rtl/uart_bist.sv
// UART loopback BIST: streams a pattern out on TX, checks it on RX,
// tracks credits and a watchdog, and reports counts and pass/fail.
module uart_bist
  import uart_bist_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int PATTERN_MODE    = 1,
  parameter int NUM_WORDS       = 256,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tuser,
  output logic                 s_axis_tready,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] sent_cnt,
  output logic [CNT_WIDTH-1:0] recv_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] first_err_idx,
  output logic [DATA_BITS-1:0] first_err_data
);

  localparam int CRW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] NUM_W   = CNT_WIDTH'(NUM_WORDS);
  localparam logic [CRW-1:0]       MAX_C   = CRW'(MAX_OUTSTANDING);
  localparam logic [WDW-1:0]       WD_LIM  = WDW'(TIMEOUT_CYCLES);

  state_t               state, state_d;
  logic [CRW-1:0]       credits, credits_d;
  logic [WDW-1:0]       wd, wd_d;
  logic [CNT_WIDTH-1:0] sent_d, recv_d, err_d, par_d, fidx_d;
  logic [DATA_BITS-1:0] fdata_d, exp_data;
  logic                 tvalid_d, timeout_d, pass_d, finish;
  logic                 active, restart, tx_hs, rx_hs;
  logic                 has_cred, unexp, mismatch, wd_fire;

  assign active   = (state == RUN) || (state == DRAIN);
  assign restart  = start && !abort && (state == IDLE || state == DONE);
  assign tx_hs    = m_axis_tvalid && m_axis_tready;
  assign rx_hs    = s_axis_tvalid && s_axis_tready && active;
  assign has_cred = (credits != '0);
  assign unexp    = rx_hs && !has_cred;
  assign mismatch = rx_hs && has_cred && (s_axis_tdata != exp_data);
  assign wd_fire  = active && !rx_hs && has_cred && (wd == WD_LIM - 1'b1);
  assign busy     = active;
  assign done     = (state == DONE);

  bist_pattern_gen #(
    .DATA_BITS   (DATA_BITS),
    .PATTERN_MODE(PATTERN_MODE)
  ) u_tx_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .reseed (restart),
    .advance(tx_hs),
    .data   (m_axis_tdata)
  );

  bist_pattern_gen #(
    .DATA_BITS   (DATA_BITS),
    .PATTERN_MODE(PATTERN_MODE)
  ) u_rx_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .reseed (restart),
    .advance(rx_hs && has_cred),
    .data   (exp_data)
  );

  always_comb begin
    state_d   = state;
    finish    = 1'b0;
    timeout_d = timeout;
    pass_d    = pass;
    fidx_d    = first_err_idx;
    fdata_d   = first_err_data;
    credits_d = credits;
    if (tx_hs && !(rx_hs && has_cred)) credits_d = credits + 1'b1;
    else if (!tx_hs && rx_hs && has_cred) credits_d = credits - 1'b1;
    wd_d = wd;
    if (rx_hs) wd_d = '0;
    else if (active && has_cred) wd_d = wd + 1'b1;
    sent_d = (tx_hs && sent_cnt != CNT_MAX) ? sent_cnt + 1'b1 : sent_cnt;
    recv_d = (rx_hs && recv_cnt != CNT_MAX) ? recv_cnt + 1'b1 : recv_cnt;
    err_d  = ((unexp || mismatch) && err_cnt != CNT_MAX) ?
             err_cnt + 1'b1 : err_cnt;
    par_d  = (rx_hs && s_axis_tuser && par_err_cnt != CNT_MAX) ?
             par_err_cnt + 1'b1 : par_err_cnt;
    // all-ones index marks "no data error latched yet"
    if (mismatch && first_err_idx == CNT_MAX) begin
      fidx_d  = recv_cnt;
      fdata_d = s_axis_tdata;
    end

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) state_d = RUN;
        RUN: begin
          if (wd_fire) begin
            state_d = DONE;
            finish  = 1'b1;
          end else if (sent_cnt == NUM_W) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (wd_fire || !has_cred) begin
            state_d = DONE;
            finish  = 1'b1;
          end
        end
      endcase
    end

    if (finish) begin
      timeout_d = wd_fire;
      pass_d    = !wd_fire && err_d == '0 && par_d == '0 && recv_d == NUM_W;
    end

    if (restart) begin
      credits_d = '0;
      wd_d      = '0;
      sent_d    = '0;
      recv_d    = '0;
      err_d     = '0;
      par_d     = '0;
      fidx_d    = CNT_MAX;
      fdata_d   = '0;
      timeout_d = 1'b0;
      pass_d    = 1'b0;
    end

    tvalid_d = (state_d == RUN) && (credits_d < MAX_C) && (sent_d < NUM_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      credits        <= '0;
      wd             <= '0;
      m_axis_tvalid  <= 1'b0;
      s_axis_tready  <= 1'b0;
      timeout        <= 1'b0;
      pass           <= 1'b0;
      sent_cnt       <= '0;
      recv_cnt       <= '0;
      err_cnt        <= '0;
      par_err_cnt    <= '0;
      first_err_idx  <= CNT_MAX;
      first_err_data <= '0;
    end else begin
      state          <= state_d;
      credits        <= credits_d;
      wd             <= wd_d;
      m_axis_tvalid  <= tvalid_d;
      s_axis_tready  <= 1'b1;
      timeout        <= timeout_d;
      pass           <= pass_d;
      sent_cnt       <= sent_d;
      recv_cnt       <= recv_d;
      err_cnt        <= err_d;
      par_err_cnt    <= par_d;
      first_err_idx  <= fidx_d;
      first_err_data <= fdata_d;
    end
  end

endmodule

// File: tb/tb_uart_bist.sv
// Randomised loopback bench for uart_bist with a transaction-level model.
// A delay-queue stands in for the UART; the model is checked every cycle.
module tb_uart_bist;

  localparam int DB = 8;
  localparam int NW = 24;
  localparam int MO = 4;
  localparam int TO = 60;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DB-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DB-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tready;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] sent_cnt, recv_cnt, err_cnt, par_err_cnt, first_err_idx;
  logic [DB-1:0] first_err_data;

  always #5 clk = ~clk;

  uart_bist #(
    .DATA_BITS      (DB),
    .PATTERN_MODE   (1),
    .NUM_WORDS      (NW),
    .MAX_OUTSTANDING(MO),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .sent_cnt      (sent_cnt),
    .recv_cnt      (recv_cnt),
    .err_cnt       (err_cnt),
    .par_err_cnt   (par_err_cnt),
    .first_err_idx (first_err_idx),
    .first_err_data(first_err_data)
  );

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  logic [DB-1:0] pat[NW];

  // model: 0 idle, 1 run, 2 drain, 3 done
  int m_st = 0;
  int m_sent, m_recv, m_err, m_par, m_cred, m_wd, m_chk;
  int m_fidx = 32'hFFFF;
  int m_fdata, m_to, m_pass, m_has_err;

  logic [DB:0] q_beat[$];
  int          q_due[$];
  int last_due = 0;
  int deliv = 0;
  int corrupt_idx = -1;
  int par_idx = -1;
  int block_after = -1;
  int stall = 0;
  int inject = 0;
  logic          prev_stall = 1'b0;
  logic [DB-1:0] prev_data = '0;

  function automatic logic [15:0] ref_next(input logic [15:0] s);
    int   taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= s[16 - taps[i]];
    return {fb, s[15:1]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      if (nfail <= 30)
        $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, a, e);
    end
  endtask

  task automatic check_outputs();
    logic exp_tv;
    exp_tv = (m_st == 1) && (m_cred < MO) && (m_sent < NW);
    chk("tready", 32'(s_axis_tready), 32'd1);
    chk("busy", 32'(busy), 32'(m_st == 1 || m_st == 2));
    chk("done", 32'(done), 32'(m_st == 3));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("sent", 32'(sent_cnt), 32'(m_sent));
    chk("recv", 32'(recv_cnt), 32'(m_recv));
    chk("err", 32'(err_cnt), 32'(m_err));
    chk("par", 32'(par_err_cnt), 32'(m_par));
    chk("fidx", 32'(first_err_idx), 32'(m_fidx));
    chk("fdata", 32'(first_err_data), 32'(m_fdata));
    chk("tvalid", 32'(m_axis_tvalid), 32'(exp_tv));
    if (exp_tv) chk("tdata", 32'(m_axis_tdata), 32'(pat[m_sent]));
    if (m_st == 3) chk("pass", 32'(pass), 32'(m_pass));
    if (prev_stall)
      chk("tx_hold", 32'({m_axis_tvalid, m_axis_tdata}),
          32'({1'b1, prev_data}));
  endtask

  task automatic model_update(input bit st, input bit ab,
                              input bit txh, input bit rxh);
    int  oc, os;
    bit  act, fire, fin;
    act = (m_st == 1 || m_st == 2);
    if (st && !ab && (m_st == 0 || m_st == 3)) begin
      {m_sent, m_recv, m_err, m_par, m_cred, m_wd, m_chk} = '0;
      m_fidx = 32'hFFFF; m_fdata = 0; m_to = 0; m_pass = 0;
      m_has_err = 0; m_st = 1;
      return;
    end
    oc = m_cred; os = m_sent;
    fire = act && !rxh && oc > 0 && (m_wd + 1 == TO);
    fin = 1'b0;
    if (txh) m_sent++;
    if (rxh) begin
      if (oc == 0) m_err++;
      else begin
        if (s_axis_tdata != pat[m_chk]) begin
          m_err++;
          if (!m_has_err) begin
            m_has_err = 1; m_fidx = m_recv; m_fdata = s_axis_tdata;
          end
        end
        m_chk++;
      end
      if (s_axis_tuser) m_par++;
      m_recv++;
    end
    m_cred = oc + int'(txh) - int'(rxh && oc > 0);
    if (rxh) m_wd = 0;
    else if (act && oc > 0) m_wd++;
    if (ab) m_st = 0;
    else if (m_st == 1) begin
      if (fire) begin m_st = 3; fin = 1; end
      else if (os == NW) m_st = 2;
    end else if (m_st == 2) begin
      if (fire || oc == 0) begin m_st = 3; fin = 1; end
    end
    if (fin) begin
      m_to = fire;
      m_pass = !fire && m_err == 0 && m_par == 0 && m_recv == NW;
    end
  endtask

  task automatic step(input bit st, input bit ab);
    bit txh, rxh;
    logic [DB-1:0] d;
    int lat;
    check_outputs();
    start = st;
    abort = ab;
    m_axis_tready = (stall > 0) ? 1'b0 : ($urandom_range(99) < 70);
    if (stall > 0) stall--;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = 1'b0;
    if (q_due.size() > 0 && q_due[0] <= cyc &&
        (block_after < 0 || deliv < block_after)) begin
      void'(q_due.pop_front());
      {s_axis_tuser, s_axis_tdata} = q_beat.pop_front();
      s_axis_tvalid = 1'b1;
      deliv++;
    end else if (inject != 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = DB'($urandom);
      inject = 0;
    end
    txh = m_axis_tvalid && m_axis_tready;
    rxh = s_axis_tvalid && (m_st == 1 || m_st == 2);
    if (txh) begin
      d = m_axis_tdata;
      if (m_sent == corrupt_idx) d[0] = ~d[0];
      lat = cyc + $urandom_range(6, 2);
      last_due = (lat > last_due) ? lat : last_due + 1;
      q_due.push_back(last_due);
      q_beat.push_back({m_sent == par_idx, d});
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data = m_axis_tdata;
    model_update(st, ab, txh, rxh);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic new_run();
    q_due.delete();
    q_beat.delete();
    last_due = 0;
    deliv = 0;
    step(1'b1, 1'b0);
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (m_st != 3 && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("run_budget", 32'(m_st == 3), 32'd1);
    inject = 1;
    repeat (3) step(1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < NW; i++) begin
      pat[i] = s[DB-1:0];
      s = ref_next(s);
    end
    chk("pat0", 32'(pat[0]), 32'h00E1);
    chk("pat1", 32'(pat[1]), 32'h0070);
    chk("pat2", 32'(pat[2]), 32'h0038);
    chk("pat5", 32'(pat[5]), 32'h0067);

    @(negedge clk);
    @(negedge clk);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_fidx", 32'(first_err_idx), 32'hFFFF);
    chk("rst_busy", 32'({busy, done, pass, timeout, m_axis_tvalid}), 32'd0);
    chk("rst_cnt", 32'(sent_cnt | recv_cnt | err_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // clean run
    new_run();
    chk("first_beat", 32'({m_axis_tvalid, m_axis_tdata}), 32'h01E1);
    run_to_done(600);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_recv", 32'(recv_cnt), 32'(NW));
    chk("t1_err", 32'(err_cnt), 32'd0);

    // bit-0 flip on beat 5
    corrupt_idx = 5;
    new_run();
    run_to_done(600);
    corrupt_idx = -1;
    chk("t2_err", 32'(err_cnt), 32'd1);
    chk("t2_fidx", 32'(first_err_idx), 32'd5);
    chk("t2_fdata", 32'(first_err_data), 32'h66);
    chk("t2_pass", 32'(pass), 32'd0);

    // TX back-pressure mid-run
    new_run();
    while (m_sent < 6 && m_st == 1) step(1'b0, 1'b0);
    stall = 40;
    run_to_done(600);
    chk("t3_pass", 32'(pass), 32'd1);

    // parity flag on beat 2
    par_idx = 2;
    new_run();
    run_to_done(600);
    par_idx = -1;
    chk("t4_par", 32'(par_err_cnt), 32'd1);
    chk("t4_pass", 32'(pass), 32'd0);

    // abort, then restart
    new_run();
    repeat (10) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);
    chk("t5_idle", 32'({busy, done}), 32'd0);
    new_run();
    chk("t5_clear", 32'(sent_cnt), 32'd0);
    run_to_done(600);
    chk("t5_pass", 32'(pass), 32'd1);

    // unexpected beat while nothing is outstanding
    new_run();
    inject = 1;
    step(1'b0, 1'b0);
    run_to_done(600);
    chk("t6_err", 32'(err_cnt), 32'd1);
    chk("t6_fidx", 32'(first_err_idx), 32'hFFFF);
    chk("t6_pass", 32'(pass), 32'd0);

    // RX blocked after 3 beats -> watchdog
    block_after = 3;
    new_run();
    run_to_done(400);
    block_after = -1;
    chk("t7_timeout", 32'(timeout), 32'd1);
    chk("t7_recv", 32'(recv_cnt), 32'd3);
    chk("t7_pass", 32'(pass), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
